// File: rtl/row_write_scheduler.sv
// Per-cycle round-robin write scheduler for one BRAM/DFU row: NUM_MUL lanes compete for NUM_WR write ports.
// Optional macro ROW_WRITE_COALESCE_EN also grants same-index candidates alongside each port winner.
module row_write_scheduler #(
    parameter int NUM_MUL     = 4,
    parameter int NUM_WR      = 8,
    parameter int PORT_WIDTH  = 3,
    parameter int INDEX_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hold,
    input  logic [NUM_MUL-1:0]            req_valid,
    input  logic [NUM_MUL*INDEX_WIDTH-1:0] req_index,
    input  logic [NUM_MUL*PORT_WIDTH-1:0] req_port,
    output logic [NUM_MUL-1:0]            req_ready,
    output logic [NUM_WR*NUM_MUL-1:0]     arbiter_result,
    output logic [NUM_WR-1:0]             write_reg_0_valid,
    output logic [NUM_WR*INDEX_WIDTH-1:0] write_reg_0_index,
    output logic [15:0]                   grant_count
);
    localparam int PTR_W = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

    // Handshake: lane m's request is consumed at the rising edge where req_valid[m] && req_ready[m];
    // req_ready is combinational and never asserts while hold is high.

    logic [NUM_MUL-1:0][INDEX_WIDTH-1:0] lane_idx;
    logic [NUM_MUL-1:0][PORT_WIDTH-1:0]  lane_port;
    logic [NUM_WR-1:0][NUM_MUL-1:0]      cand;
    logic [NUM_WR-1:0][NUM_MUL-1:0]      grant;
    logic [NUM_WR-1:0]                   win_found;
    logic [NUM_WR-1:0][PTR_W-1:0]        win_lane;
    logic [NUM_WR-1:0][INDEX_WIDTH-1:0]  win_index;

    logic [NUM_WR-1:0][PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_WR-1:0][NUM_MUL-1:0]      arb_q, arb_d;
    logic [NUM_WR-1:0]                   val_q, val_d;
    logic [NUM_WR-1:0][INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic [15:0]                         cnt_q, cnt_d;
    logic [16:0]                         cnt_sum;

    assign lane_idx  = req_index;
    assign lane_port = req_port;

    // Ports outside 0..NUM_WR-1 match no w, so such lanes are simply never candidates.
    always_comb begin
        cand = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int m = 0; m < NUM_MUL; m++) begin
                cand[w][m] = req_valid[m] && (lane_port[m] == PORT_WIDTH'(w));
            end
        end
    end

    always_comb begin
        grant     = '0;
        win_found = '0;
        win_lane  = '0;
        win_index = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int k = 0; k < NUM_MUL; k++) begin
                logic [PTR_W-1:0] lane;
                lane = PTR_W'((int'(ptr_q[w]) + k) % NUM_MUL);
                if (!win_found[w] && cand[w][lane]) begin
                    win_found[w] = 1'b1;
                    win_lane[w]  = lane;
                    win_index[w] = lane_idx[lane];
                end
            end
            if (!hold) begin
`ifdef ROW_WRITE_COALESCE_EN
                for (int m = 0; m < NUM_MUL; m++) begin
                    if (win_found[w] && cand[w][m] && (lane_idx[m] == win_index[w]))
                        grant[w][m] = 1'b1;
                end
`else
                if (win_found[w])
                    grant[w][win_lane[w]] = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            req_ready = req_ready | grant[w];
        end
    end

    // The pointer advances past the round-robin winner only, even when extra lanes were coalesced.
    always_comb begin
        ptr_d   = ptr_q;
        arb_d   = grant;
        val_d   = '0;
        idx_d   = '0;
        cnt_sum = {1'b0, cnt_q};
        for (int w = 0; w < NUM_WR; w++) begin
            val_d[w] = |grant[w];
            if (val_d[w]) begin
                idx_d[w] = win_index[w];
                ptr_d[w] = PTR_W'((int'(win_lane[w]) + 1) % NUM_MUL);
            end
            for (int m = 0; m < NUM_MUL; m++) begin
                cnt_sum = cnt_sum + 17'(grant[w][m]);
            end
        end
        cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            arb_q <= '0;
            val_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            arb_q <= arb_d;
            val_q <= val_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign arbiter_result    = arb_q;
    assign write_reg_0_valid = val_q;
    assign write_reg_0_index = idx_q;
    assign grant_count       = cnt_q;

endmodule

// File: tb/tb_row_write_scheduler.sv
// Self-checking bench for row_write_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_row_write_scheduler;
    logic clk;
    logic reset;

    logic        hold_r;
    logic [3:0]  in_v;
    logic [11:0] in_idx [4];
    logic [2:0]  in_p   [4];

    logic [3:0]  ready;
    logic [31:0] arb;
    logic [7:0]  val;
    logic [95:0] idx;
    logic [15:0] cnt;

    logic [3:0]  v4;
    logic [2:0]  p4 [4];
    logic [3:0]  ready4;
    logic [15:0] arb4;
    logic [3:0]  val4;
    logic [47:0] idx4;
    logic [15:0] cnt4;

    int n_tests;
    int n_fail;

    row_write_scheduler #(.NUM_MUL(4), .NUM_WR(8), .PORT_WIDTH(3), .INDEX_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .hold(hold_r),
        .req_valid(in_v),
        .req_index({in_idx[3], in_idx[2], in_idx[1], in_idx[0]}),
        .req_port({in_p[3], in_p[2], in_p[1], in_p[0]}),
        .req_ready(ready), .arbiter_result(arb), .write_reg_0_valid(val),
        .write_reg_0_index(idx), .grant_count(cnt)
    );

    row_write_scheduler #(.NUM_MUL(4), .NUM_WR(4), .PORT_WIDTH(3), .INDEX_WIDTH(12)) dut4 (
        .clk(clk), .reset(reset), .hold(1'b0),
        .req_valid(v4),
        .req_index({12'h333, 12'h222, 12'h111, 12'h7FF}),
        .req_port({p4[3], p4[2], p4[1], p4[0]}),
        .req_ready(ready4), .arbiter_result(arb4), .write_reg_0_valid(val4),
        .write_reg_0_index(idx4), .grant_count(cnt4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int          m_ptr [8];
    int          m_win [8];
    logic [7:0][3:0] exp_grant;
    logic [3:0]  exp_ready;
    logic [31:0] m_arb;
    logic [7:0]  m_val;
    logic [95:0] m_idx;
    logic [15:0] m_cnt;
    logic [15:0] m4_cnt;
    logic [3:0]  exp4_ready;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 8; w++) m_ptr[w] = 0;
        m_arb = '0; m_val = '0; m_idx = '0; m_cnt = '0; m4_cnt = '0;
    endfunction

    // Round-robin: first requester for port w at or after ptr, wrapping; optional same-index merge.
    function automatic void model_eval();
        exp_grant = '0;
        exp_ready = '0;
        for (int w = 0; w < 8; w++) begin
            int win;
            win = -1;
            for (int k = 0; k < 4; k++) begin
                int l;
                l = (m_ptr[w] + k) % 4;
                if (win < 0 && in_v[l] && int'(in_p[l]) == w) win = l;
            end
            m_win[w] = win;
            if (win >= 0 && !hold_r) begin
                exp_grant[w][win] = 1'b1;
`ifdef ROW_WRITE_COALESCE_EN
                for (int m = 0; m < 4; m++)
                    if (in_v[m] && int'(in_p[m]) == w && in_idx[m] == in_idx[win]) exp_grant[w][m] = 1'b1;
`endif
            end
            exp_ready = exp_ready | exp_grant[w];
        end
        for (int m = 0; m < 4; m++) exp4_ready[m] = v4[m] && (p4[m] < 3'd4);
    endfunction

    function automatic void model_commit();
        int pop;
        int pop4;
        pop = 0;
        pop4 = 0;
        m_arb = exp_grant;
        m_idx = '0;
        for (int w = 0; w < 8; w++) begin
            m_val[w] = |exp_grant[w];
            if (m_val[w]) begin
                m_idx[w*12 +: 12] = in_idx[m_win[w]];
                m_ptr[w] = (m_win[w] + 1) % 4;
            end
            for (int m = 0; m < 4; m++) pop += int'(exp_grant[w][m]);
        end
        for (int m = 0; m < 4; m++) pop4 += int'(exp4_ready[m]);
        m_cnt  = (int'(m_cnt) + pop > 65535) ? 16'hFFFF : 16'(int'(m_cnt) + pop);
        m4_cnt = (int'(m4_cnt) + pop4 > 65535) ? 16'hFFFF : 16'(int'(m4_cnt) + pop4);
    endfunction

    // driver: inputs already set shortly after an edge; check ready, clock once, check registers
    task automatic step();
        #1;
        model_eval();
        check_eq("req_ready", ready, exp_ready);
        check_eq("req_ready4", ready4, exp4_ready);
        @(posedge clk);
        model_commit();
        #1;
        check_eq("arbiter_result", arb, m_arb);
        check_eq("wr_valid", val, m_val);
        check_eq("wr_index", idx, m_idx);
        check_eq("grant_count", cnt, m_cnt);
        check_eq("grant_count4", cnt4, m4_cnt);
    endtask

    task automatic clear_inputs();
        hold_r = 1'b0; in_v = '0; v4 = '0;
        for (int m = 0; m < 4; m++) begin in_idx[m] = '0; in_p[m] = '0; p4[m] = '0; end
    endtask

    task automatic set_lane(input int m, input logic [2:0] p, input logic [11:0] ix);
        in_v[m] = 1'b1; in_p[m] = p; in_idx[m] = ix;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_arb"}, arb, 0);
        check_eq({tag, "_val"}, val, 0);
        check_eq({tag, "_idx"}, idx, 0);
        check_eq({tag, "_cnt"}, cnt, 0);
        check_eq({tag, "_cnt4"}, cnt4, 0);
    endtask

    // Asserted between edges: outputs must clear without waiting for a clock.
    task automatic mid_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        model_eval();
        check_eq("reset_ready", ready, exp_ready);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int saved;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
        reset = 1'b1;

        // all lanes on port 2: strict rotation 0,1,2,3,0
        for (int m = 0; m < 4; m++) set_lane(m, 3'd2, 12'(16 + m));
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("rr_walk", arb[11:8], 4'b0001 << (i % 4));
            check_eq("rr_valid", val, 8'b0000_0100);
        end

        // one lane per port 0..3
        for (int m = 0; m < 4; m++) set_lane(m, 3'(m), 12'(32 + m));
        step();
        check_eq("par_arb", arb, 32'h0000_8421);
        check_eq("par_valid", val, 8'h0F);
        check_eq("par_cnt", cnt, 16'd9);

        // lanes 1 and 3 on untouched port 5 with equal index
        clear_inputs();
        set_lane(1, 3'd5, 12'h0A5);
        set_lane(3, 3'd5, 12'h0A5);
        step();
`ifdef ROW_WRITE_COALESCE_EN
        check_eq("coal_arb", arb[23:20], 4'b1010);
        check_eq("coal_cnt", cnt, 16'd11);
`else
        check_eq("nocoal_arb0", arb[23:20], 4'b0010);
        step();
        check_eq("nocoal_arb1", arb[23:20], 4'b1000);
        check_eq("nocoal_cnt", cnt, 16'd11);
`endif

        // hold for three cycles with all lanes pending on port 2
        clear_inputs();
        for (int m = 0; m < 4; m++) set_lane(m, 3'd2, 12'(64 + m));
        step();
        hold_r = 1'b1;
        #1;
        model_eval();
        saved = m_win[2];
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_ready", ready, 4'b0000);
            check_eq("hold_valid", val, 8'h00);
        end
        hold_r = 1'b0;
        step();
        check_eq("post_hold_winner", arb[11:8], 4'b0001 << saved);

        // NUM_WR=4 instance: lane 0 aimed at port 7 is never served
        clear_inputs();
        for (int i = 0; i < 40; i++) begin
            v4 = 4'($urandom_range(0, 15));
            p4[0] = 3'd7;
            for (int m = 1; m < 4; m++) p4[m] = 3'(m + 4 * $urandom_range(0, 1));
            step();
            check_eq("bad_port_ready", ready4[0], 1'b0);
        end
        v4 = '0;

        // randomized traffic with narrow index range to provoke equal-index collisions
        for (int i = 0; i < 1500; i++) begin
            hold_r = ($urandom_range(0, 7) == 0);
            in_v = 4'($urandom_range(0, 15));
            for (int m = 0; m < 4; m++) begin
                in_p[m]   = 3'($urandom_range(0, 7));
                in_idx[m] = 12'($urandom_range(0, 3));
            end
            step();
        end

        // reset mid-stream, then contested port 6 must go to lane 0 first
        clear_inputs();
        for (int m = 0; m < 4; m++) set_lane(m, 3'd6, 12'(200 + m));
        step();
        step();
        mid_reset();
        step();
        check_eq("post_reset_winner", arb[27:24], 4'b0001);

        // saturate grant_count with four grants per cycle
        for (int m = 0; m < 4; m++) set_lane(m, 3'(m), 12'(300 + m));
        for (int i = 0; i < 16400; i++) step();
        check_eq("sat_cnt", cnt, 16'hFFFF);
        clear_inputs();
        set_lane(0, 3'd1, 12'h001);
        set_lane(2, 3'd3, 12'h002);
        step();
        check_eq("sat_hold", cnt, 16'hFFFF);
        check_eq("sat_valid", val, 8'h0A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
